kvaz_sdram_port: RTL

KVAZ_SDRAM_PORT -- requirements
Module: kvaz_sdram_port

---
 rtl/kvaz_pkg.sv | 19 +
 rtl/kvaz_sdram_port.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/kvaz_pkg.sv
// rtl/kvaz_pkg.sv - shared state encoding, defaults and byte-lane helper for the ramdisk SDRAM port
package kvaz_pkg;

  localparam int KVAZ_ADDR_TIMEOUT = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ADDR = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4
  } kvaz_state_t;

  // Odd bus addresses live in the low byte of the SDRAM word.
  function automatic logic [7:0] kvaz_pick_byte(input logic a0, input logic [15:0] word);
    return a0 ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/kvaz_sdram_port.sv
// rtl/kvaz_sdram_port.sv - turns ramdisk bus read/write strobes into single-word SDRAM controller requests
module kvaz_sdram_port
  import kvaz_pkg::*;
#(
  parameter int ADDR_TIMEOUT = KVAZ_ADDR_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        blk_n,
  input  logic        negedge_zpzu_n,
  input  logic        negedge_chtzu_n,
  input  logic [15:0] decoded_a,
  input  logic        decoded_a_valid,
  input  logic [2:0]  kvaz_page,
  input  logic [7:0]  wdata,
  input  logic        posedge_ras_n,
  input  logic        clean_cas_n,
  output logic [21:0] sdram_addr,
  output logic [15:0] sdram_dataw,
  output logic        sdram_rd,
  output logic        sdram_we_n,
  output logic        sdram_lb_n,
  output logic        sdram_ub_n,
  output logic        sdram_refresh,
  input  logic [15:0] sdram_datar,
  input  logic        sdram_busy,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        pending,
  output logic        overrun,
  output logic        addr_timeout
);

  localparam int CNT_W = $clog2(ADDR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_TIMEOUT - 1);

  kvaz_state_t      state;
  logic             is_read;
  logic [18:0]      addr_lat;
  logic [7:0]       wbyte;
  logic [CNT_W-1:0] tmo_cnt;

  logic write_req;
  logic read_req;
  logic refresh_ok;

  assign write_req  = ~blk_n & negedge_zpzu_n;
  assign read_req   = ~blk_n & negedge_chtzu_n;
  assign refresh_ok = (state == ST_IDLE) & blk_n & posedge_ras_n & clean_cas_n
                    & ~(write_req | read_req);

  assign sdram_addr  = {4'b0, addr_lat[18:1]};
  assign sdram_dataw = {wbyte, wbyte};
  assign pending     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      is_read       <= 1'b0;
      addr_lat      <= '0;
      wbyte         <= '0;
      tmo_cnt       <= '0;
      sdram_rd      <= 1'b0;
      sdram_we_n    <= 1'b1;
      sdram_lb_n    <= 1'b1;
      sdram_ub_n    <= 1'b1;
      sdram_refresh <= 1'b0;
      rdata         <= '0;
      rdata_valid   <= 1'b0;
      overrun       <= 1'b0;
      addr_timeout  <= 1'b0;
    end else begin
      sdram_rd      <= 1'b0;
      sdram_we_n    <= 1'b1;
      rdata_valid   <= 1'b0;
      addr_timeout  <= 1'b0;
      sdram_refresh <= refresh_ok;
      // Outside IDLE every strobe is lost; in IDLE only a read colliding with a write is.
      overrun <= (state != ST_IDLE) ? (write_req | read_req) : (write_req & read_req);

      case (state)
        ST_IDLE: begin
          sdram_lb_n <= 1'b1;
          sdram_ub_n <= 1'b1;
          if (write_req) begin
            is_read    <= 1'b0;
            addr_lat   <= {kvaz_page, decoded_a};
            wbyte      <= wdata;
            sdram_lb_n <= ~decoded_a[0];
            sdram_ub_n <= decoded_a[0];
            state      <= ST_ISSUE;
          end else if (read_req) begin
            is_read <= 1'b1;
            tmo_cnt <= '0;
            if (decoded_a_valid) begin
              addr_lat   <= {kvaz_page, decoded_a};
              sdram_lb_n <= ~decoded_a[0];
              sdram_ub_n <= decoded_a[0];
              state      <= ST_ISSUE;
            end else begin
              state <= ST_WAIT_ADDR;
            end
          end
        end

        ST_WAIT_ADDR: begin
          if (decoded_a_valid) begin
            addr_lat   <= {kvaz_page, decoded_a};
            sdram_lb_n <= ~decoded_a[0];
            sdram_ub_n <= decoded_a[0];
            tmo_cnt    <= '0;
            state      <= ST_ISSUE;
          end else if (tmo_cnt == CNT_LAST) begin
            addr_timeout <= 1'b1;
            tmo_cnt      <= '0;
            state        <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_ISSUE: begin
          if (!sdram_busy) begin
            sdram_rd   <= is_read;
            sdram_we_n <= is_read;
            state      <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (!sdram_busy) state <= is_read ? ST_CAPTURE : ST_IDLE;
        end

        ST_CAPTURE: begin
          rdata       <= kvaz_pick_byte(addr_lat[0], sdram_datar);
          rdata_valid <= 1'b1;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
